// File: rtl/acq_seq_pkg.sv
// Shared types and constants for the acquisition sequencer and its hit buffer.
// Build-time geometry falls back to these values when not set by the project.
`ifndef Np
`define Np 12
`endif
`ifndef PIXEL_NUM
`define PIXEL_NUM 16
`endif
`ifndef ACQ_NUM
`define ACQ_NUM 4
`endif

package acq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } acq_state_e;

  // Value streamed for a pixel that saw no timestamp during the shot.
  localparam int NO_HIT = 0;

  localparam int HB_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/hit_buffer.sv
// Per-pixel first-hit timestamp store: flagged write port, bulk clear,
// and a registered sequential read port that forwards a same-cycle write.
module hit_buffer
  import acq_seq_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int NP    = 12,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [NP-1:0] wr_data,
  output logic          wr_hit,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [NP-1:0] rd_data
);

  logic [NP-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] flag_q, flag_d;
  logic [NP-1:0]    rd_data_q, rd_data_d;

  assign wr_hit  = flag_q[wr_addr];
  assign rd_data = rd_data_q;

  always_comb begin
    flag_d    = flag_q;
    rd_data_d = NP'(NO_HIT);
    if (clr) begin
      flag_d = '0;
    end else if (wr_en) begin
      flag_d[wr_addr] = 1'b1;
    end
    // A hit landing on the same edge the read is issued must not be missed.
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else if (flag_q[rd_addr]) begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      flag_q    <= '0;
      rd_data_q <= '0;
    end else begin
      flag_q    <= flag_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Frame sequencer: collects first-hit timestamps per pixel during a laser shot,
// streams them to the histogram builder, then waits for the peak result.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter  int NP         = `Np,
  parameter  int PIXEL_NUM  = `PIXEL_NUM,
  parameter  int ACQ_NUM    = `ACQ_NUM,
  parameter  int HB_LATENCY = HB_LATENCY_DEFAULT,
  localparam int PW         = $clog2(PIXEL_NUM),
  localparam int AW         = $clog2(ACQ_NUM + 1),
  localparam int DW         = $clog2(HB_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          abort,
  input  logic          shot_end,
  input  logic          tdc_valid,
  input  logic [PW-1:0] tdc_pix,
  input  logic [NP-1:0] tdc_data,
  output logic          hb_wrEn,
  output logic [NP-1:0] hb_data,
  output logic          busy,
  output logic [AW-1:0] acq_cnt,
  output logic          peak_capture,
  output logic          frame_done,
  output logic          tdc_drop,
  output logic          overrun
);

  acq_state_e    state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [AW-1:0] acq_cnt_q, acq_cnt_d;
  logic          overrun_q, overrun_d;
  logic          hb_wr_en_q, hb_wr_en_d;
  logic          tdc_drop_q, tdc_drop_d;

  logic          buf_clr, buf_wr, buf_hit, buf_rd;
  logic [PW-1:0] buf_rd_addr;
  logic          pix_ok;

  assign pix_ok = int'(tdc_pix) < PIXEL_NUM;

  hit_buffer #(
    .DEPTH (PIXEL_NUM),
    .NP    (NP)
  ) u_hit_buffer (
    .clk     (clk),
    .res     (res),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_addr (tdc_pix),
    .wr_data (tdc_data),
    .wr_hit  (buf_hit),
    .rd_en   (buf_rd),
    .rd_addr (buf_rd_addr),
    .rd_data (hb_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    acq_cnt_d   = acq_cnt_q;
    overrun_d   = overrun_q;
    hb_wr_en_d  = 1'b0;
    tdc_drop_d  = 1'b0;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
    buf_rd_addr = '0;

    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      drain_d = '0;
      buf_clr = 1'b1;
    end else begin
      // Late timestamps and stray shot ends are only flagged while busy.
      if (state_q != ST_IDLE && state_q != ST_COLLECT) begin
        tdc_drop_d = tdc_valid;
        if (shot_end) overrun_d = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_COLLECT;
            acq_cnt_d = '0;
            overrun_d = 1'b0;
            buf_clr   = 1'b1;
          end
        end
        ST_COLLECT: begin
          if (tdc_valid) begin
            if (pix_ok && !buf_hit) buf_wr = 1'b1;
            else tdc_drop_d = 1'b1;
          end
          if (shot_end) begin
            state_d    = ST_STREAM;
            idx_d      = '0;
            buf_rd     = 1'b1;
            hb_wr_en_d = 1'b1;
          end
        end
        ST_STREAM: begin
          if (idx_q == PW'(PIXEL_NUM - 1)) begin
            acq_cnt_d = acq_cnt_q + 1'b1;
            buf_clr   = 1'b1;
            drain_d   = '0;
            state_d   = (int'(acq_cnt_d) < ACQ_NUM) ? ST_COLLECT : ST_DRAIN;
          end else begin
            idx_d       = idx_q + 1'b1;
            buf_rd      = 1'b1;
            buf_rd_addr = idx_d;
            hb_wr_en_d  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DW'(HB_LATENCY - 1)) state_d = ST_DONE;
          else drain_d = drain_q + 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      drain_q    <= '0;
      acq_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      hb_wr_en_q <= 1'b0;
      tdc_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      acq_cnt_q  <= acq_cnt_d;
      overrun_q  <= overrun_d;
      hb_wr_en_q <= hb_wr_en_d;
      tdc_drop_q <= tdc_drop_d;
    end
  end

  assign hb_wrEn      = hb_wr_en_q;
  assign busy         = (state_q != ST_IDLE);
  assign acq_cnt      = acq_cnt_q;
  assign peak_capture = (state_q == ST_DRAIN) && (drain_q == DW'(HB_LATENCY - 1));
  assign frame_done   = (state_q == ST_DONE);
  assign tdc_drop     = tdc_drop_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed and randomized bench for acq_sequencer; each shot's expected burst
// is built from the hit list with a first-hit-per-pixel table.
module tb_acq_sequencer;

  localparam int NP         = 12;
  localparam int PIXEL_NUM  = 3;
  localparam int ACQ_NUM    = 2;
  localparam int HB_LATENCY = 4;
  localparam int PW         = $clog2(PIXEL_NUM);
  localparam int AW         = $clog2(ACQ_NUM + 1);

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          shot_end = 1'b0;
  logic          tdc_valid = 1'b0;
  logic [PW-1:0] tdc_pix = '0;
  logic [NP-1:0] tdc_data = '0;
  logic          hb_wrEn;
  logic [NP-1:0] hb_data;
  logic          busy;
  logic [AW-1:0] acq_cnt;
  logic          peak_capture;
  logic          frame_done;
  logic          tdc_drop;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  int fd_cnt = 0;
  int exp_acq = 0;
  int hit_pix[$];
  int hit_dat[$];

  acq_sequencer #(
    .NP         (NP),
    .PIXEL_NUM  (PIXEL_NUM),
    .ACQ_NUM    (ACQ_NUM),
    .HB_LATENCY (HB_LATENCY)
  ) dut (
    .clk          (clk),
    .res          (res),
    .start        (start),
    .abort        (abort),
    .shot_end     (shot_end),
    .tdc_valid    (tdc_valid),
    .tdc_pix      (tdc_pix),
    .tdc_data     (tdc_data),
    .hb_wrEn      (hb_wrEn),
    .hb_data      (hb_data),
    .busy         (busy),
    .acq_cnt      (acq_cnt),
    .peak_capture (peak_capture),
    .frame_done   (frame_done),
    .tdc_drop     (tdc_drop),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tdc_drop === 1'b1) drop_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_acq = 0;
    chk("start_busy", 32'(busy), 1);
    chk("start_acq_cnt", 32'(acq_cnt), 0);
    chk("start_overrun", 32'(overrun), 0);
  endtask

  task automatic rand_hits();
    int n;
    n = int'($urandom_range(0, 5));
    for (int i = 0; i < n; i++) begin
      hit_pix.push_back(int'($urandom_range(0, PIXEL_NUM)));
      hit_dat.push_back(int'($urandom_range(1, (1 << NP) - 1)));
    end
  endtask

  // Drive the queued hits, end the shot, and check the burst and its aftermath.
  task automatic run_shot(input int ovr_at, input bit coincide, input bit last_shot);
    int  want_w[PIXEL_NUM];
    bit  seen[PIXEL_NUM];
    int  want_drop, d0, n, lat;
    want_drop = 0;
    for (int p = 0; p < PIXEL_NUM; p++) begin
      want_w[p] = 0;
      seen[p]   = 1'b0;
    end
    n = hit_pix.size();
    for (int i = 0; i < n; i++) begin
      if (hit_pix[i] >= PIXEL_NUM || seen[hit_pix[i]]) begin
        want_drop++;
      end else begin
        seen[hit_pix[i]]   = 1'b1;
        want_w[hit_pix[i]] = hit_dat[i];
      end
    end
    d0 = drop_cnt;
    for (int i = 0; i < n; i++) begin
      tdc_valid = 1'b1;
      tdc_pix   = PW'(hit_pix[i]);
      tdc_data  = NP'(hit_dat[i]);
      shot_end  = coincide && (i == n - 1);
      tick();
      tdc_valid = 1'b0;
    end
    if (!(coincide && n > 0)) begin
      shot_end = 1'b1;
      tick();
    end
    shot_end = 1'b0;
    for (int k = 0; k < PIXEL_NUM; k++) begin
      chk($sformatf("stream_wren[%0d]", k), 32'(hb_wrEn), 1);
      chk($sformatf("stream_word[%0d]", k), 32'(hb_data), want_w[k]);
      shot_end = (k == ovr_at);
      if (k < PIXEL_NUM - 1 && $urandom_range(0, 1) == 1) begin
        tdc_valid = 1'b1;
        tdc_pix   = PW'($urandom_range(0, PIXEL_NUM - 1));
        want_drop++;
      end
      tick();
      shot_end  = 1'b0;
      tdc_valid = 1'b0;
    end
    exp_acq++;
    chk("burst_end_wren", 32'(hb_wrEn), 0);
    chk("acq_cnt", 32'(acq_cnt), exp_acq);
    chk("drop_count", drop_cnt - d0, want_drop);
    if (ovr_at >= 0) chk("overrun_set", 32'(overrun), 1);
    if (last_shot) begin
      lat = 1;
      while (peak_capture !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      chk("peak_latency", lat, HB_LATENCY);
      tick();
      chk("frame_done", 32'(frame_done), 1);
      chk("peak_one_cycle", 32'(peak_capture), 0);
      tick();
      chk("frame_idle_busy", 32'(busy), 0);
      chk("frame_done_pulse", 32'(frame_done), 0);
    end else begin
      chk("collect_busy", 32'(busy), 1);
    end
    hit_pix.delete();
    hit_dat.delete();
  endtask

  initial begin
    int fd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wren", 32'(hb_wrEn), 0);
    chk("rst_data", 32'(hb_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acq_cnt", 32'(acq_cnt), 0);
    chk("rst_peak", 32'(peak_capture), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_drop", 32'(tdc_drop), 0);
    chk("rst_overrun", 32'(overrun), 0);
    res = 1'b1;
    tick();

    // Timestamps in IDLE are ignored without a drop pulse.
    tdc_valid = 1'b1;
    tdc_pix   = 1;
    tick();
    tdc_valid = 1'b0;
    tick();
    chk("idle_no_drop", drop_cnt, 0);
    chk("idle_busy", 32'(busy), 0);

    // Full frame with fixed timestamps; second shot hits pix2 with shot_end.
    start_frame();
    hit_pix = '{0, 1, 2};
    hit_dat = '{108, 511, 1022};
    run_shot(-1, 1'b0, 1'b0);
    hit_pix = '{2};
    hit_dat = '{90};
    run_shot(-1, 1'b1, 1'b1);

    // First hit wins, out-of-range pixel dropped, shot_end during STREAM.
    start_frame();
    hit_pix = '{1, 1, 3};
    hit_dat = '{200, 300, 77};
    run_shot(1, 1'b0, 1'b0);
    rand_hits();
    run_shot(-1, 1'($urandom_range(0, 1)), 1'b1);
    start_frame();
    rand_hits();
    run_shot(-1, 1'b0, 1'b0);
    rand_hits();
    run_shot(-1, 1'b0, 1'b1);

    // Abort on the second STREAM cycle.
    start_frame();
    tdc_valid = 1'b1;
    tdc_pix   = 0;
    tdc_data  = 5;
    shot_end  = 1'b1;
    tick();
    tdc_valid = 1'b0;
    shot_end  = 1'b0;
    chk("abort_stream_wren", 32'(hb_wrEn), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wren", 32'(hb_wrEn), 0);
    chk("abort_busy", 32'(busy), 0);
    fd0 = fd_cnt;
    repeat (8) tick();
    chk("abort_no_frame_done", fd_cnt, fd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);

    // Reset asserted in the middle of a burst.
    start_frame();
    rand_hits();
    run_shot(-1, 1'b0, 1'b0);
    tdc_valid = 1'b1;
    tdc_pix   = 1;
    tdc_data  = 33;
    shot_end  = 1'b1;
    tick();
    tdc_valid = 1'b0;
    shot_end  = 1'b0;
    chk("rst_mid_wren_before", 32'(hb_wrEn), 1);
    #3;
    res = 1'b0;
    #1;
    chk("rst_mid_wren", 32'(hb_wrEn), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_acq_cnt", 32'(acq_cnt), 0);
    chk("rst_mid_data", 32'(hb_data), 0);
    #2;
    res = 1'b1;
    repeat (4) tick();
    chk("rst_release_wren", 32'(hb_wrEn), 0);
    chk("rst_release_busy", 32'(busy), 0);
    start_frame();
    rand_hits();
    run_shot(-1, 1'b0, 1'b0);
    rand_hits();
    run_shot(-1, 1'b1, 1'b1);

    // Randomized frames.
    repeat (8) begin
      start_frame();
      for (int a = 0; a < ACQ_NUM; a++) begin
        rand_hits();
        run_shot(int'($urandom_range(0, PIXEL_NUM)) - 1, 1'($urandom_range(0, 1)),
                 a == ACQ_NUM - 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter NP, default `Np, meaning timestamp width in bits.
REQ-002 SHALL have parameter PIXEL_NUM, default `PIXEL_NUM, meaning pixels per acquisition.
REQ-003 SHALL have parameter ACQ_NUM, default `ACQ_NUM, meaning acquisitions per frame.
REQ-004 SHALL have parameter HB_LATENCY, default 4, meaning histogram-builder cycles from last write to valid peakResult.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on the rising edge.
REQ-006 SHALL have port res  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1  one-cycle frame start request.
REQ-008 SHALL have port abort  in  1  synchronous frame abort.
REQ-009 SHALL have port shot_end  in  1  one-cycle end-of-laser-shot strobe.
REQ-010 SHALL have port tdc_valid  in  1  timestamp present this cycle.
REQ-011 SHALL have port tdc_pix  in  $clog2(PIXEL_NUM)  pixel index of timestamp.
REQ-012 SHALL have port tdc_data  in  NP  timestamp.
REQ-013 SHALL have port hb_wrEn  out  1  histogram-builder write enable.
REQ-014 SHALL have port hb_data  out  NP  histogram-builder data.
REQ-015 SHALL have port busy  out  1  high outside IDLE.
REQ-016 SHALL have port acq_cnt  out  $clog2(ACQ_NUM+1)  completed acquisitions in this frame.
REQ-017 SHALL have port peak_capture  out  1  one-cycle pulse; peakResult valid this cycle.
REQ-018 SHALL have port frame_done  out  1  one-cycle pulse, cycle after peak_capture.
REQ-019 SHALL have port tdc_drop  out  1  one-cycle pulse, timestamp discarded.
REQ-020 SHALL have port overrun  out  1  sticky: shot_end seen outside COLLECT while busy.

Function
REQ-021 SHALL implement states IDLE, COLLECT, STREAM, DRAIN, DONE.
REQ-022 IDLE -> COLLECT on start; acq_cnt, overrun, hit buffer cleared same edge.
REQ-023 In COLLECT, tdc_valid SHALL store tdc_data for tdc_pix only if that pixel has no hit yet (first hit wins); otherwise pulse tdc_drop next cycle.
REQ-024 tdc_pix >= PIXEL_NUM SHALL be discarded with tdc_drop.
REQ-025 COLLECT -> STREAM on shot_end; tdc_valid coincident with shot_end SHALL be stored before streaming.
REQ-026 STREAM SHALL last exactly PIXEL_NUM cycles, hb_wrEn=1, hb_data=pixel 0..PIXEL_NUM-1 in order, registered outputs, first word on cycle after shot_end.
REQ-027 Pixel without hit SHALL emit hb_data=0 with hb_wrEn=1 to keep pixel alignment.
REQ-028 After last STREAM word, acq_cnt SHALL increment and hit buffer clear; -> COLLECT if acq_cnt<ACQ_NUM, else -> DRAIN.
REQ-029 tdc_valid in STREAM/DRAIN/DONE/IDLE SHALL pulse tdc_drop (except IDLE: silently ignored).
REQ-030 shot_end in STREAM or DRAIN SHALL set overrun; state unaffected.
REQ-031 DRAIN SHALL wait HB_LATENCY cycles, pulse peak_capture on the last, then -> DONE.
REQ-032 DONE SHALL pulse frame_done for one cycle, then -> IDLE.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 abort SHALL force IDLE next edge from any state, hb_wrEn=0, buffer cleared, no frame_done; abort wins over simultaneous start.
REQ-035 hb_wrEn SHALL be 0 in every state except STREAM.

Reset
REQ-036 res low SHALL asynchronously force IDLE, all outputs 0, acq_cnt 0, overrun 0, hit buffer flags 0.
REQ-037 Reset mid-STREAM SHALL truncate the write burst immediately; no resumption after release.

Structure
REQ-038 State enum, NO_HIT value (0) and default HB_LATENCY SHALL live in shared package acq_seq_pkg.
REQ-039 Per-pixel timestamp storage with hit flags, write port and sequential read port SHALL be sub-module hit_buffer.

Verification
REQ-040 PIXEL_NUM=3, ACQ_NUM=2: start, hits pix0=108,pix1=511,pix2=1022, shot_end -> hb_data 108,511,1022 on 3 consecutive cycles, acq_cnt=1.
REQ-041 Second shot hits pix2=90 only -> hb_data 0,0,90; DRAIN; peak_capture HB_LATENCY cycles after last write; frame_done next cycle; busy=0.
REQ-042 Two hits pix1=200 then pix1=300 in one shot -> streamed pix1=200, one tdc_drop pulse.
REQ-043 shot_end during STREAM -> overrun=1, burst still 3 words, cleared by next start.
REQ-044 abort on second STREAM cycle -> hb_wrEn=0 next cycle, IDLE, no frame_done; start+abort same cycle -> stays IDLE.
REQ-045 res low mid-STREAM -> outputs 0 asynchronously; after release, start begins a fresh frame with acq_cnt=0.
